// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream crossbar.
package stream_xbar_pkg;

    // Index widths never collapse to zero, even for single-port configurations.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int BEAT_DATA_W = 8;
    localparam int BEAT_ID_W   = 1;

    // Beat layout held in the skid buffers: data in the MSBs, last in the LSB.
    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic [BEAT_ID_W-1:0]   id;
        logic                   last;
    } beat_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready register slice with a registered output.
// r_head always holds the oldest beat, r_tail the second one when full.
module stream_skid_buf #(
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign in_ready_o  = (r_count != 2'd2);
    assign out_valid_o = (r_count != 2'd0);
    assign out_data_o  = r_head;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= in_data_i;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= in_data_i;
                    end else if (w_push) begin
                        r_tail  <= in_data_i;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // A push cannot coincide here because in_ready is low.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_xbar_rr.sv
// AXI-Stream crossbar: slaves route whole packets by TDEST to masters, each master
// arbitrating round-robin with packet locking and feeding a 2-entry skid buffer.
module stream_xbar_rr
    import stream_xbar_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = clog2_min1(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    output logic [S_DATA_COUNT-1:0]                   s_ready_o,
    output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
    output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o,
    output logic [M_DATA_COUNT-1:0]                   m_last_o,
    output logic [M_DATA_COUNT-1:0]                   m_valid_o,
    input  logic [M_DATA_COUNT-1:0]                   m_ready_i
);

    localparam int BEAT_W = T_DATA_WIDTH + T_ID___WIDTH + 1;

    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] w_eff_dest;
    logic [S_DATA_COUNT-1:0]                   w_dest_ok;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_gnt_all;
    logic [M_DATA_COUNT-1:0]                   w_buf_ready;

    genvar gi, gj;

    generate
        for (gi = 0; gi < S_DATA_COUNT; gi++) begin : g_slave
            logic                    r_in_pkt;
            logic [T_DEST_WIDTH-1:0] r_cur_dest;
            logic [M_DATA_COUNT-1:0] w_hit;

            // Only the first beat of a packet looks at s_dest_i.
            assign w_eff_dest[gi] = r_in_pkt ? r_cur_dest : s_dest_i[gi];
            assign w_dest_ok[gi]  = {1'b0, w_eff_dest[gi]} < (T_DEST_WIDTH+1)'(M_DATA_COUNT);

            for (gj = 0; gj < M_DATA_COUNT; gj++) begin : g_hit
                assign w_hit[gj] = w_gnt_all[gj][gi] & w_buf_ready[gj];
            end

            // Packets with an unroutable destination are swallowed so they cannot stall the slave.
            assign s_ready_o[gi] = ~w_dest_ok[gi] | (|w_hit);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_in_pkt   <= 1'b0;
                    r_cur_dest <= '0;
                end else if (s_valid_i[gi] && s_ready_o[gi]) begin
                    if (!r_in_pkt) begin
                        r_cur_dest <= s_dest_i[gi];
                    end
                    r_in_pkt <= ~s_last_i[gi];
                end
            end
        end

        for (gi = 0; gi < M_DATA_COUNT; gi++) begin : g_master
            arb_state_t              r_state;
            arb_state_t              w_state_next;
            logic [T_ID___WIDTH-1:0] r_ptr;
            logic [T_ID___WIDTH-1:0] w_ptr_next;
            logic [T_ID___WIDTH-1:0] r_owner;
            logic [T_ID___WIDTH-1:0] w_owner_next;
            logic [T_ID___WIDTH-1:0] w_sel;
            logic [T_ID___WIDTH-1:0] w_idx;
            logic [S_DATA_COUNT-1:0] w_req;
            logic [S_DATA_COUNT-1:0] w_gnt;
            logic                    w_push;
            logic                    w_hs;
            logic                    w_last;
            logic [BEAT_W-1:0]       w_in_beat;
            logic [BEAT_W-1:0]       w_out_beat;

            for (gj = 0; gj < S_DATA_COUNT; gj++) begin : g_req
                assign w_req[gj] = s_valid_i[gj] & w_dest_ok[gj]
                                 & (w_eff_dest[gj] == T_DEST_WIDTH'(gj * 0 + gi));
            end

            // Scanning from farthest to nearest leaves the first requester after r_ptr in w_gnt.
            always_comb begin
                w_gnt = '0;
                w_sel = '0;
                w_idx = '0;
                if (r_state == ARB_LOCKED) begin
                    w_gnt[r_owner] = 1'b1;
                    w_sel          = r_owner;
                end else begin
                    for (int k = S_DATA_COUNT; k >= 1; k--) begin
                        w_idx = T_ID___WIDTH'((int'(r_ptr) + k) % S_DATA_COUNT);
                        if (w_req[w_idx]) begin
                            w_gnt        = '0;
                            w_gnt[w_idx] = 1'b1;
                            w_sel        = w_idx;
                        end
                    end
                end
            end

            assign w_push          = |(w_gnt & s_valid_i);
            assign w_hs            = w_push & w_buf_ready[gi];
            assign w_last          = s_last_i[w_sel];
            assign w_gnt_all[gi]   = w_gnt;
            assign w_in_beat       = {s_data_i[w_sel], w_sel, w_last};

            always_comb begin
                w_state_next = r_state;
                w_ptr_next   = r_ptr;
                w_owner_next = r_owner;
                case (r_state)
                    ARB_IDLE: begin
                        if (w_hs) begin
                            if (w_last) begin
                                w_ptr_next = w_sel;
                            end else begin
                                w_state_next = ARB_LOCKED;
                                w_owner_next = w_sel;
                            end
                        end
                    end
                    ARB_LOCKED: begin
                        if (w_hs && w_last) begin
                            w_state_next = ARB_IDLE;
                            w_ptr_next   = r_owner;
                        end
                    end
                    default: w_state_next = ARB_IDLE;
                endcase
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_state <= ARB_IDLE;
                    r_ptr   <= T_ID___WIDTH'(S_DATA_COUNT - 1);
                    r_owner <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_ptr   <= w_ptr_next;
                    r_owner <= w_owner_next;
                end
            end

            stream_skid_buf #(
                .WIDTH (BEAT_W)
            ) u_skid (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .in_valid_i  (w_push),
                .in_ready_o  (w_buf_ready[gi]),
                .in_data_i   (w_in_beat),
                .out_valid_o (m_valid_o[gi]),
                .out_ready_i (m_ready_i[gi]),
                .out_data_o  (w_out_beat)
            );

            assign m_data_o[gi] = w_out_beat[BEAT_W-1 -: T_DATA_WIDTH];
            assign m_id_o[gi]   = w_out_beat[T_ID___WIDTH:1];
            assign m_last_o[gi] = w_out_beat[0];
        end
    endgenerate

endmodule

// File: tb/tb_stream_xbar_rr.sv
// Bench for stream_xbar_rr: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of routing, arbitration and buffering.
module tb_stream_xbar_rr;

    localparam int W = 8, S = 2, M = 3, IDW = 1, DW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [S-1:0][W-1:0] s_data = '0;
    logic [S-1:0][DW-1:0] s_dest = '0;
    logic [S-1:0]        s_last = '0;
    logic [S-1:0]        s_valid = '0;
    logic [S-1:0]        s_ready;
    logic [M-1:0][W-1:0] m_data;
    logic [M-1:0][IDW-1:0] m_id;
    logic [M-1:0]        m_last;
    logic [M-1:0]        m_valid;
    logic [M-1:0]        m_ready = '1;

    always #5 clk = ~clk;

    stream_xbar_rr #(
        .T_DATA_WIDTH (W),
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M),
        .T_ID___WIDTH (IDW),
        .T_DEST_WIDTH (DW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_data_i  (s_data),
        .s_dest_i  (s_dest),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_id_o    (m_id),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_m(input string name, input int m, input int id, input bit last, input logic [7:0] d);
        chk(name, {21'd0, m_valid[m], m_id[m], m_last[m], m_data[m]},
            {21'd0, 1'b1, 1'(id), last, d});
    endtask

    // Reference model: per-master FIFO of expected beats, packet lock and RR pointer.
    typedef struct {
        logic [7:0] d;
        int         id;
        bit         last;
    } beat_t;

    beat_t q [M][$];
    bit    md_locked [M];
    int    md_owner [M];
    int    md_ptr [M];
    int    md_len [M];
    bit    md_in_pkt [S];
    int    md_cur_dest [S];
    bit    hs [S];
    int    eff [S];
    bit    rdy_exp [S];
    int    gnt [M];
    int    cand;

    always @(negedge clk) begin
        if (rst) begin
            for (int m = 0; m < M; m++) begin
                q[m].delete();
                md_locked[m] = 1'b0;
                md_ptr[m]    = S - 1;
                md_len[m]    = 0;
            end
            for (int s = 0; s < S; s++) begin
                md_in_pkt[s] = 1'b0;
                hs[s]        = 1'b0;
            end
            chk("reset_m_valid", 32'(m_valid), 32'd0);
            chk("reset_m_data", 32'(m_data), 32'd0);
            chk("reset_m_id_last", {26'd0, m_id, m_last}, 32'd0);
        end else begin
            for (int s = 0; s < S; s++) begin
                eff[s] = md_in_pkt[s] ? md_cur_dest[s] : int'(s_dest[s]);
                hs[s]  = 1'b0;
            end
            for (int m = 0; m < M; m++) begin
                gnt[m] = -1;
                if (md_locked[m]) begin
                    gnt[m] = md_owner[m];
                end else begin
                    for (int k = 1; k <= S; k++) begin
                        cand = (md_ptr[m] + k) % S;
                        if (gnt[m] < 0 && s_valid[cand] && eff[cand] == m) gnt[m] = cand;
                    end
                end
            end
            for (int s = 0; s < S; s++) begin
                rdy_exp[s] = (eff[s] >= M) ? 1'b1 : (gnt[eff[s]] == s && q[eff[s]].size() < 2);
                if (s_valid[s]) chk($sformatf("s_ready[%0d]", s), 32'(s_ready[s]), 32'(rdy_exp[s]));
            end
            for (int m = 0; m < M; m++) begin
                chk($sformatf("m_valid[%0d]", m), 32'(m_valid[m]), 32'(q[m].size() > 0));
                if (q[m].size() > 0) begin
                    chk($sformatf("m_data[%0d]", m), 32'(m_data[m]), 32'(q[m][0].d));
                    chk($sformatf("m_id[%0d]", m), 32'(m_id[m]), 32'(q[m][0].id));
                    chk($sformatf("m_last[%0d]", m), 32'(m_last[m]), 32'(q[m][0].last));
                end
            end
            for (int m = 0; m < M; m++) begin
                if (q[m].size() > 0 && m_ready[m]) begin
                    md_len[m]++;
                    if (q[m][0].last) begin
                        $display("xfer: master %0d <- slave %0d, %0d beats", m, q[m][0].id, md_len[m]);
                        md_len[m] = 0;
                    end
                    void'(q[m].pop_front());
                end
            end
            for (int s = 0; s < S; s++) begin
                if (s_valid[s] && rdy_exp[s]) begin
                    hs[s] = 1'b1;
                    if (eff[s] < M) begin
                        q[eff[s]].push_back('{d: s_data[s], id: s, last: s_last[s]});
                        if (s_last[s]) begin
                            md_locked[eff[s]] = 1'b0;
                            md_ptr[eff[s]]    = s;
                        end else begin
                            md_locked[eff[s]] = 1'b1;
                            md_owner[eff[s]]  = s;
                        end
                    end
                    if (!md_in_pkt[s]) md_cur_dest[s] = eff[s];
                    md_in_pkt[s] = ~s_last[s];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input bit v, input logic [7:0] d, input int dest, input bit last);
        s_valid[s] = v;
        s_data[s]  = d;
        s_dest[s]  = DW'(dest);
        s_last[s]  = last;
    endtask

    logic [7:0] got [$];
    int         idx;
    int         rem [S];
    int         pdest [S];
    bit         fresh [S];

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("post_reset_valid", 32'(m_valid), 32'd0);
        tick();

        // Single three-beat packet, slave 1 -> master 1.
        drive(1, 1, 8'h5A, 1, 0);
        #1 chk("t1_ready", 32'(s_ready[1]), 32'd1);
        tick(); chk_m("t1_beat0", 1, 1, 0, 8'h5A);
        drive(1, 1, 8'h6B, 1, 0);
        tick(); chk_m("t1_beat1", 1, 1, 0, 8'h6B);
        drive(1, 1, 8'h7C, 1, 1);
        tick(); chk_m("t1_beat2", 1, 1, 1, 8'h7C);
        drive(1, 0, 8'h00, 0, 0);
        tick(); chk("t1_idle", 32'(m_valid[1]), 32'd0);

        // Contention on master 2: packets must not interleave.
        drive(0, 1, 8'hA0, 2, 0);
        drive(1, 1, 8'hB0, 2, 0);
        #1 chk("t2_first_grant", 32'(s_ready), 32'd1);
        tick(); chk_m("t2_a0", 2, 0, 0, 8'hA0);
        drive(0, 1, 8'hA1, 2, 1);
        #1 chk("t2_locked_out", 32'(s_ready[1]), 32'd0);
        tick(); chk_m("t2_a1", 2, 0, 1, 8'hA1);
        drive(0, 0, 8'h00, 0, 0);
        #1 chk("t2_second_grant", 32'(s_ready[1]), 32'd1);
        tick(); chk_m("t2_b0", 2, 1, 0, 8'hB0);
        drive(1, 1, 8'hB1, 2, 1);
        tick(); chk_m("t2_b1", 2, 1, 1, 8'hB1);
        drive(1, 0, 8'h00, 0, 0);
        tick();

        // Alternating single-beat packets on master 0.
        drive(0, 1, 8'h10, 0, 1);
        drive(1, 1, 8'h11, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_m($sformatf("t3_rr%0d", i), 0, i % 2, 1, 8'(8'h10 + i % 2));
        end
        drive(0, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0);
        tick();

        // Backpressure: master 0 stalls for three cycles.
        idx = 0;
        drive(0, 1, 8'h01, 0, 0);
        for (int c = 0; c < 20; c++) begin
            m_ready[0] = (c >= 3);
            if (m_valid[0] && m_ready[0]) got.push_back(m_data[0]);
            if (c == 2) begin
                #1 chk("t4_full_backpressure", 32'(s_ready[0]), 32'd0);
            end
            tick();
            if (s_valid[0] && hs[0]) begin
                idx++;
                if (idx < 4) drive(0, 1, 8'(idx + 1), 0, idx == 3);
                else s_valid[0] = 1'b0;
            end
        end
        m_ready[0] = 1'b1;
        chk("t4_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("t4_order%0d", i), 32'(got[i]), 32'(i + 1));

        // Unroutable destination is consumed silently; later beat's dest is ignored.
        drive(0, 1, 8'hD0, 3, 0);
        #1 chk("t5_ready0", 32'(s_ready[0]), 32'd1);
        tick(); chk("t5_drop0", 32'(m_valid), 32'd0);
        drive(0, 1, 8'hD1, 1, 1);
        #1 chk("t5_ready1", 32'(s_ready[0]), 32'd1);
        tick(); chk("t5_drop1", 32'(m_valid), 32'd0);
        drive(0, 1, 8'h77, 1, 1);
        tick(); chk_m("t5_after", 1, 0, 1, 8'h77);
        drive(0, 0, 8'h00, 0, 0);
        tick();

        // Asynchronous reset in the middle of a packet.
        drive(0, 1, 8'hE0, 0, 0);
        tick(); chk_m("t6_beat0", 0, 0, 0, 8'hE0);
        drive(0, 1, 8'hE1, 0, 0);
        #2 rst = 1'b1;
        #1 chk("t6_async_reset", 32'(m_valid), 32'd0);
        drive(0, 0, 8'h00, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        drive(1, 1, 8'hF0, 0, 1);
        #1 chk("t6_regrant", 32'(s_ready[1]), 32'd1);
        tick(); chk_m("t6_id1", 0, 1, 1, 8'hF0);
        drive(1, 0, 8'h00, 0, 0);
        tick();

        // Random traffic with random backpressure.
        for (int s = 0; s < S; s++) begin
            rem[s]   = 0;
            fresh[s] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < S; s++) begin
                if (!(s_valid[s] && !hs[s])) begin
                    if (s_valid[s] && hs[s]) begin
                        rem[s]--;
                        fresh[s] = 1'b0;
                    end
                    s_valid[s] = 1'b0;
                    if (rem[s] == 0 && $urandom_range(0, 1) == 1) begin
                        rem[s]   = $urandom_range(1, 4);
                        pdest[s] = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
                        fresh[s] = 1'b1;
                    end
                    if (rem[s] > 0 && $urandom_range(0, 4) != 0)
                        drive(s, 1, 8'($urandom), fresh[s] ? pdest[s] : $urandom_range(0, 3), rem[s] == 1);
                end
            end
            for (int m = 0; m < M; m++) m_ready[m] = ($urandom_range(0, 3) != 0);
            tick();
        end

        s_valid = '0;
        m_ready = '1;
        repeat (6) tick();
        chk("drain_empty", 32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_xbar_rr.md
Name: stream_xbar_rr

Overview:
Parametrised successor to the stream commutator. A full AXI-Stream crossbar: S_DATA_COUNT slaves route packets to M_DATA_COUNT masters by per-slave TDEST. Each master runs a round-robin arbiter that locks onto one slave for a whole packet, so packets never interleave. Each master output goes through a registered 2-entry skid buffer, which gives full throughput and real s_ready_o backpressure. It replaces the separate request-matrix and commutator pair at the top of the switch.

Parameters:
T_DATA_WIDTH, 8, data width per beat
S_DATA_COUNT, 2, number of slave (input) ports, >=1
M_DATA_COUNT, 3, number of master (output) ports, >=1
T_ID___WIDTH, $clog2(S_DATA_COUNT) (min 1), width of m_id_o
T_DEST_WIDTH, $clog2(M_DATA_COUNT) (min 1), width of s_dest_i

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
s_data_i  in  [T_DATA_WIDTH-1:0] x S_DATA_COUNT  slave data
s_dest_i  in  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  target master index
s_last_i  in  [S_DATA_COUNT-1:0]  end-of-packet beat
s_valid_i  in  [S_DATA_COUNT-1:0]  slave valid
s_ready_o  out  [S_DATA_COUNT-1:0]  slave ready
m_data_o  out  [T_DATA_WIDTH-1:0] x M_DATA_COUNT  master data
m_id_o  out  [T_ID___WIDTH-1:0] x M_DATA_COUNT  source slave index
m_last_o  out  [M_DATA_COUNT-1:0]  end-of-packet
m_valid_o  out  [M_DATA_COUNT-1:0]  master valid
m_ready_i  in  [M_DATA_COUNT-1:0]  master ready

Behaviour:
- Reset (async assert, sync release): m_valid_o=0, m_data_o=0, m_id_o=0, m_last_o=0. Skid buffers emptied, all locks cleared, RR pointers set to S_DATA_COUNT-1 so slave 0 has top priority. Asserting reset mid-packet discards buffered beats and partial packets. No recovery state is kept.
- Slave handshake: a beat transfers on s_valid_i & s_ready_o. A slave holding s_valid_i must keep data, dest and last stable until the beat transfers.
- Slave-side dest latch: s_dest_i is sampled on the first beat of a packet (slave in_pkt=0) into cur_dest. Remaining beats route to cur_dest and s_dest_i is ignored. in_pkt sets on a non-last handshake and clears on a last handshake. A single-beat packet (last on first beat) never sets in_pkt.
- Invalid dest (>= M_DATA_COUNT): s_ready_o=1 and beats are consumed and dropped until last. Nothing reaches any master. This prevents deadlock.
- Per-master arbiter FSM, states IDLE and LOCKED:
  - IDLE: requesters are slaves with valid and effective dest == m. Grant goes to the first requester after ptr, modulo S_DATA_COUNT, combinationally in the same cycle.
  - On a granted handshake with last=0: go to LOCKED, owner=grant.
  - On a granted handshake with last=1: stay IDLE, ptr=grant.
  - LOCKED: only the owner is granted. On the owner's last handshake: go to IDLE, ptr=owner. Owner valid low means the master idles and does not re-arbitrate.
  - The pointer updates only on packet completion.
- s_ready_o[s] = grant[dest(s)][s] & buf_in_ready[dest(s)]. At most one master grants a given slave.
- Skid buffer per master: 2 entries {data,id,last}.
  - in_ready = count<2.
  - The output is registered, so latency from slave handshake to m_valid_o is 1 cycle.
  - Full rate (1 beat/cycle) when m_ready_i is held high.
  - Simultaneous push and pop while full is impossible because in_ready=0. Push and pop at count 1 keeps count 1.
  - Order is FIFO. No beat is lost or duplicated.
- Different masters run fully in parallel, with no cross-master coupling.
- m_id_o carries the granted slave index, zero-extended.

Decomposition:
- Package stream_xbar_pkg: clog2-with-min-1 function, arbiter state enum (ARB_IDLE, ARB_LOCKED), beat struct typedef {data,id,last} parametrised via localparam widths.
- Sub-module stream_skid_buf: a 2-entry valid/ready register slice, instantiated M_DATA_COUNT times.
- Arbiter logic stays inline in a generate loop.

Test Plan (S=2, M=3, W=8, m_ready_i=3'b111 unless stated):
- Slave1, dest 1, beats 5A,6B,7C (last on 7C) on consecutive cycles -> m_data_o[1] shows 5A,6B,7C one cycle after each handshake. id=1, m_last_o[1] only with 7C, s_ready_o[1] stays 1.
- Slaves 0 and 1 both dest 2 in the same cycle, packets A0,A1 / B0,B1 -> master 2 outputs A0,A1 (id 0) then B0,B1 (id 1) with no interleave. s_ready_o[1]=0 until A1 transfers.
- Both slaves send repeated single-beat packets to dest 0 -> m_id_o[0] sequence 0,1,0,1. Simultaneously a slave-1 stream to dest 2 while slave 0 targets dest 0 -> both masters at full rate.
- Slave0 stream 01,02,03,04 to dest 0 with m_ready_i[0]=0 for 3 cycles -> buffer holds 01,02, then s_ready_o[0]=0. On release the master outputs 01,02,03,04 in order with no loss.
- Slave0 dest 3 (invalid), 2 beats -> both accepted, all m_valid_o stay 0. A following packet to dest 1 is delivered normally.
- rst_i pulsed during beat 2 of a 3-beat slave-0 packet to dest 0 -> m_valid_o=0 asynchronously. After release, a slave-1 packet to dest 0 is granted immediately with id=1.
